// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN digit-classifier sequencer.
package snn_pkg;

  localparam int unsigned IMG_BYTES  = 98;
  localparam int unsigned IMG_PIXELS = 784;
  localparam int unsigned BYTE_CNT_W = 7;

  typedef enum logic [2:0] {
    StIdle,
    StUnpack,
    StWaitByte,
    StStartCore,
    StWaitCore,
    StSend
  } snn_seq_state_t;

endpackage

// File: rtl/snn_rx_timer.sv
// Inter-byte idle counter: clear has priority, expired flags the last allowed cycle.
module snn_rx_timer #(
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = (cnt_q == CntW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/snn_seq_ctrl.sv
// Image loader / core launcher / result sender for the SNN classifier.
module snn_seq_ctrl #(
  parameter int unsigned IMG_BYTES   = snn_pkg::IMG_BYTES,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  input  logic              tx_rdy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              core_start,
  input  logic              core_done,
  input  logic [3:0]        core_digit,
  input  logic [ADDR_W-1:0] core_addr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_data,
  output logic              ram_we,
  output logic [3:0]        digit,
  output logic              busy,
  output logic              err_ovr,
  output logic              err_timeout
);
  import snn_pkg::*;

  localparam logic [BYTE_CNT_W-1:0] LastByte = BYTE_CNT_W'(IMG_BYTES - 1);

  snn_seq_state_t          state_q, state_d;
  logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [2:0]              bit_idx_q, bit_idx_d;
  logic [7:0]              shift_q, shift_d;
  logic [7:0]              hold_q, hold_d;
  logic                    pending_q, pending_d;
  logic [3:0]              digit_q, digit_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    err_ovr_q, err_ovr_d;
  logic                    err_to_q, err_to_d;
  logic                    tmr_clr, tmr_en, tmr_expired;

  snn_rx_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      hold_q     <= '0;
      pending_q  <= 1'b0;
      digit_q    <= '0;
      tx_data_q  <= '0;
      err_ovr_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      pending_q  <= pending_d;
      digit_q    <= digit_d;
      tx_data_q  <= tx_data_d;
      err_ovr_q  <= err_ovr_d;
      err_to_q   <= err_to_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    pending_d  = pending_q;
    digit_d    = digit_q;
    tx_data_d  = tx_data_q;
    err_ovr_d  = err_ovr_q;
    err_to_d   = err_to_q;
    tmr_clr    = 1'b1;
    tmr_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_rdy) begin
          shift_d = rx_data;
          state_d = StUnpack;
        end
      end
      StUnpack: begin
        bit_idx_d = bit_idx_q + 3'd1;
        if (bit_idx_q == 3'd7) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == LastByte) begin
            // Anything beyond the last image byte has nowhere to go.
            state_d   = StStartCore;
            pending_d = 1'b0;
            if (pending_q || rx_rdy) err_ovr_d = 1'b1;
          end else if (pending_q) begin
            shift_d = hold_q;
            if (rx_rdy) hold_d = rx_data;
            else        pending_d = 1'b0;
          end else if (rx_rdy) begin
            // Byte landing on the final bit cycle chains straight into the next unpack.
            shift_d = rx_data;
          end else begin
            state_d = StWaitByte;
          end
        end else if (rx_rdy) begin
          if (pending_q) begin
            err_ovr_d = 1'b1;
          end else begin
            hold_d    = rx_data;
            pending_d = 1'b1;
          end
        end
      end
      StWaitByte: begin
        if (rx_rdy) begin
          shift_d = rx_data;
          state_d = StUnpack;
        end else begin
          tmr_clr = 1'b0;
          tmr_en  = 1'b1;
          if (tmr_expired) begin
            byte_cnt_d = '0;
            bit_idx_d  = '0;
            err_to_d   = 1'b1;
            state_d    = StIdle;
          end
        end
      end
      StStartCore: begin
        byte_cnt_d = '0;
        state_d    = StWaitCore;
        if (rx_rdy) err_ovr_d = 1'b1;
      end
      StWaitCore: begin
        if (rx_rdy) err_ovr_d = 1'b1;
        if (core_done) begin
          digit_d   = core_digit;
          tx_data_d = {4'h0, core_digit};
          state_d   = StSend;
        end
      end
      StSend: begin
        if (rx_rdy) err_ovr_d = 1'b1;
        if (tx_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // The core owns the RAM read port while it runs.
  always_comb begin
    ram_addr = ADDR_W'({byte_cnt_q, bit_idx_q});
    if (state_q == StStartCore || state_q == StWaitCore) ram_addr = core_addr;
  end

  assign ram_we      = (state_q == StUnpack);
  assign ram_data    = (state_q == StUnpack) & shift_q[bit_idx_q];
  assign core_start  = (state_q == StStartCore);
  assign tx_start    = (state_q == StSend) & tx_rdy;
  assign tx_data     = tx_data_q;
  assign digit       = digit_q;
  assign busy        = (state_q != StIdle);
  assign err_ovr     = err_ovr_q;
  assign err_timeout = err_to_q;

endmodule

// File: tb/tb_snn_seq_ctrl.sv
// Self-checking bench for snn_seq_ctrl: write scoreboard plus table-driven image runs.
module tb_snn_seq_ctrl;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned TIMEOUT = 1000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_rdy = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              tx_rdy = 1'b0;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              core_start;
  logic              core_done = 1'b0;
  logic [3:0]        core_digit = '0;
  logic [ADDR_W-1:0] core_addr = '0;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_data;
  logic              ram_we;
  logic [3:0]        digit;
  logic              busy;
  logic              err_ovr;
  logic              err_timeout;

  snn_seq_ctrl #(
    .IMG_BYTES  (98),
    .ADDR_W     (ADDR_W),
    .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .tx_rdy     (tx_rdy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .core_start (core_start),
    .core_done  (core_done),
    .core_digit (core_digit),
    .core_addr  (core_addr),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_we     (ram_we),
    .digit      (digit),
    .busy       (busy),
    .err_ovr    (err_ovr),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] addr;
    logic       data;
  } wr_t;

  typedef struct {
    logic [7:0] rx_byte;
    logic [9:0] core_addr;
    logic [3:0] core_digit;
    int         stall;
    logic       rx_core;
    logic [7:0] exp_tx;
    logic       exp_ovr;
  } vec_t;

  wr_t  exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rx_cyc = 0;
  int   exp_byte = 0;
  int   wr_cnt = 0;
  int   cs_cnt = 0;
  int   tx_cnt = 0;
  int   last_wr_cyc = 0;
  int   cs_cyc = 0;
  logic [ADDR_W-1:0] last_wr_addr = '0;
  vec_t vecs[4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard side: every RAM write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_we) begin
        wr_cnt++;
        last_wr_cyc  = cyc;
        last_wr_addr = ram_addr;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {22'h0, ram_addr}, 32'hFFFF_FFFF);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          chk("wr_addr", {22'h0, ram_addr}, {22'h0, w.addr});
          chk("wr_data", {31'h0, ram_data}, {31'h0, w.data});
        end
      end
      if (core_start) begin
        cs_cnt++;
        cs_cyc = cyc;
      end
      if (tx_start) tx_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    @(posedge clk);
    #1;
    rx_cyc = cyc;
    rx_rdy = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      wr_t w;
      w.addr = 10'(exp_byte * 8 + i);
      w.data = b[i];
      exp_q.push_back(w);
    end
    exp_byte++;
  endtask

  // Compressed byte spacing keeps the run short; still leaves WAIT_BYTE gaps.
  task automatic send_bytes(input logic [7:0] b, input int n);
    for (int k = 0; k < n; k++) begin
      push_byte(b);
      pulse_rx(b);
      idle(11);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {31'h0, busy}, 0);
    chk({tag, "_ram_we"}, {31'h0, ram_we}, 0);
    chk({tag, "_ram_addr"}, {22'h0, ram_addr}, 0);
    chk({tag, "_ram_data"}, {31'h0, ram_data}, 0);
    chk({tag, "_tx_start"}, {31'h0, tx_start}, 0);
    chk({tag, "_tx_data"}, {24'h0, tx_data}, 0);
    chk({tag, "_core_start"}, {31'h0, core_start}, 0);
    chk({tag, "_digit"}, {28'h0, digit}, 0);
    chk({tag, "_err_ovr"}, {31'h0, err_ovr}, 0);
    chk({tag, "_err_timeout"}, {31'h0, err_timeout}, 0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    rx_rdy    = 1'b0;
    core_done = 1'b0;
    tx_rdy    = 1'b0;
    idle(3);
    exp_q.delete();
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic run_image(input vec_t v, input logic exp_to);
    int wr0, cs0, tx0;
    wr0 = wr_cnt;
    cs0 = cs_cnt;
    tx0 = tx_cnt;
    exp_byte = 0;
    send_bytes(v.rx_byte, 98);
    for (int k = 0; k < 200 && cs_cnt == cs0; k++) @(negedge clk);
    @(posedge clk);
    #1;
    chk("core_start_count", cs_cnt - cs0, 1);
    chk("core_start_gap", cs_cyc - last_wr_cyc, 1);
    chk("write_count", wr_cnt - wr0, 784);
    chk("last_addr", {22'h0, last_wr_addr}, 783);
    chk("sb_empty", exp_q.size(), 0);
    core_addr = v.core_addr;
    @(negedge clk);
    chk("core_addr_mux", {22'h0, ram_addr}, {22'h0, v.core_addr});
    chk("core_ram_we", {31'h0, ram_we}, 0);
    chk("core_busy", {31'h0, busy}, 1);
    if (v.rx_core) begin
      @(posedge clk);
      #1;
      pulse_rx(8'hEE);
      @(negedge clk);
      chk("ovr_in_core", {31'h0, err_ovr}, 1);
      chk("ovr_ram_we", {31'h0, ram_we}, 0);
    end
    @(posedge clk);
    #1;
    tx_rdy     = (v.stall == 0);
    core_digit = v.core_digit;
    core_done  = 1'b1;
    @(posedge clk);
    #1;
    core_done = 1'b0;
    if (v.stall > 0) begin
      repeat (v.stall) @(posedge clk);
      #1;
      chk("stall_no_tx", tx_cnt - tx0, 0);
      chk("stall_busy", {31'h0, busy}, 1);
      tx_rdy = 1'b1;
    end
    @(negedge clk);
    chk("tx_start", {31'h0, tx_start}, 1);
    chk("tx_data", {24'h0, tx_data}, {24'h0, v.exp_tx});
    chk("digit", {28'h0, digit}, {28'h0, v.core_digit});
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("busy_after_send", {31'h0, busy}, 0);
    chk("tx_once", tx_cnt - tx0, 1);
    chk("tx_data_held", {24'h0, tx_data}, {24'h0, v.exp_tx});
    chk("no_late_writes", wr_cnt - wr0, 784);
    chk("err_ovr", {31'h0, err_ovr}, {31'h0, v.exp_ovr});
    chk("err_timeout", {31'h0, err_timeout}, {31'h0, exp_to});
    @(posedge clk);
    #1;
    core_addr = '0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    vecs[0] = '{rx_byte: 8'hA5, core_addr: 10'h1F3, core_digit: 4'd7, stall: 0,
                rx_core: 1'b0, exp_tx: 8'h07, exp_ovr: 1'b0};
    vecs[1] = '{rx_byte: 8'hA5, core_addr: 10'h000, core_digit: 4'd7, stall: 200,
                rx_core: 1'b0, exp_tx: 8'h07, exp_ovr: 1'b0};
    vecs[2] = '{rx_byte: 8'h3C, core_addr: 10'h2AA, core_digit: 4'd0, stall: 0,
                rx_core: 1'b0, exp_tx: 8'h00, exp_ovr: 1'b0};
    vecs[3] = '{rx_byte: 8'hFF, core_addr: 10'h3FF, core_digit: 4'd9, stall: 5,
                rx_core: 1'b1, exp_tx: 8'h09, exp_ovr: 1'b1};

    idle(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 4; i++) run_image(vecs[i], 1'b0);

    // Partial image then silence: abort exactly TIMEOUT cycles into WAIT_BYTE.
    do_reset();
    exp_byte = 0;
    send_bytes(8'h5A, 50);
    while (cyc < rx_cyc + 7 + TIMEOUT) @(negedge clk);
    chk("pre_timeout_busy", {31'h0, busy}, 1);
    chk("pre_timeout_flag", {31'h0, err_timeout}, 0);
    @(negedge clk);
    chk("timeout_flag", {31'h0, err_timeout}, 1);
    chk("timeout_idle", {31'h0, busy}, 0);
    chk("timeout_sb_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
    run_image(vecs[0], 1'b1);

    // Reset while byte 40 is being unpacked: only its first two bits land.
    exp_byte = 0;
    send_bytes(8'h33, 40);
    for (int i = 0; i < 2; i++) begin
      wr_t w;
      w.addr = 10'(320 + i);
      w.data = i[0];
      exp_q.push_back(w);
    end
    pulse_rx(8'hC6);
    idle(2);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    chk("mid_reset_sb", exp_q.size(), 0);
    idle(3);
    rst_n = 1'b1;
    idle(1);
    run_image(vecs[2], 1'b0);

    // Back-to-back bytes during UNPACK: second is held, third overflows.
    do_reset();
    exp_byte = 0;
    wr0 = wr_cnt;
    send_bytes(8'h0F, 1);
    push_byte(8'h81);
    pulse_rx(8'h81);
    idle(2);
    push_byte(8'h5A);
    pulse_rx(8'h5A);
    idle(2);
    pulse_rx(8'h3C);
    @(negedge clk);
    chk("hold_ovr", {31'h0, err_ovr}, 1);
    idle(20);
    chk("hold_sb_empty", exp_q.size(), 0);
    chk("hold_last_addr", {22'h0, last_wr_addr}, 23);
    chk("hold_writes", wr_cnt - wr0, 24);
    chk("hold_busy", {31'h0, busy}, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
